multiplex_dispatch: RTL

//  - Transmit-side counterpart of the VC merge stage: splits one 12-bit word stream across 4 virtual-channel FIFOs.
//  - Destination VC = in_data[11:10]; the full 12-bit word is forwarded unchanged.
//  - A DEPTH-entry input buffer decouples the upstream producer from the per-VC FIFO backpressure.
//  - Sits between the transaction-layer word source and the VC0..VC3 FIFOs.

---
 rtl/multiplex_dispatch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multiplex_dispatch.sv
// multiplex_dispatch: splits one word stream across four virtual-channel FIFOs.
// The destination VC is taken from the top two bits of each word. A small input
// buffer decouples the producer from per-VC backpressure. Dispatch is strictly
// in order, so a full head VC blocks all later words.
// Optional feature: define MUX_COUNTERS_EN for live per-VC push counters;
// otherwise cnt0..cnt3 are tied to zero.
module multiplex_dispatch #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              full0,
    input  logic              full1,
    input  logic              full2,
    input  logic              full3,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic              push0,
    output logic              push1,
    output logic              push2,
    output logic              push3,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [3:0] {
        LINK_RESET  = 4'b0001,
        LINK_INIT   = 4'b0010,
        LINK_IDLE   = 4'b0100,
        LINK_ACTIVE = 4'b1000
    } link_state_e;

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] p_q [4];

    logic              flush;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [1:0]        head_vc;
    logic [3:0]        full_vec;

    // Accept/pop decisions, occupancy bookkeeping and next push strobes.
    always_comb begin
        flush    = reset || (state == LINK_RESET);
        full_vec = {full3, full2, full1, full0};
        head     = mem_q[rd_ptr_q];
        head_vc  = head[DATA_W-1 -: 2];
        // A full buffer never accepts, even when the head pops in the same edge.
        accept   = in_valid && in_ready_q && (count_q != OCC_FULL);
        pop      = !flush && (count_q != '0) && !full_vec[head_vc];

        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + OCC_ONE;
        end else if (!accept && pop) begin
            count_d = count_q - OCC_ONE;
        end

        in_ready_d = (state == LINK_ACTIVE) && (count_d < OCC_FULL);

        push_d = '0;
        if (pop) begin
            push_d[head_vc] = 1'b1;
        end
    end

    // Buffer storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (!flush && accept) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Pointers, occupancy, ready flag and VC output registers.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            push_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                p_q[head_vc] <= head;
            end
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            push_q     <= push_d;
        end
    end

    assign in_ready = in_ready_q;
    assign p0       = p_q[0];
    assign p1       = p_q[1];
    assign p2       = p_q[2];
    assign p3       = p_q[3];
    assign push0    = push_q[0];
    assign push1    = push_q[1];
    assign push2    = push_q[2];
    assign push3    = push_q[3];

`ifdef MUX_COUNTERS_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Per-VC push counters; advance together with the push strobe and wrap silently.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push_d[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign cnt2 = '0;
    assign cnt3 = '0;
`endif

endmodule
